// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start bit, 8 data bits LSB first, optional
// odd/even parity, stop bit. Every bit lasts CLKS_PER_BIT clock cycles.
module uart_tx_serializer #(
  parameter int   CLKS_PER_BIT = 434,
  parameter logic IDLE_LEVEL   = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [7:0]  tx_data,
  input  logic        tx_data_en,
  input  logic [1:0]  parity_mode,
  output logic        tx_pin,
  output logic        tx_ready,
  output logic        tx_done,
  output logic [15:0] frame_cnt
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);

  logic [2:0]  state;
  logic [15:0] bit_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  data_q;
  logic [1:0]  mode_q;

  logic bit_end;
  logic has_parity;
  logic parity_bit;

  assign bit_end    = (bit_cnt == BIT_LAST);
  assign has_parity = (mode_q == 2'b01) || (mode_q == 2'b10);
  // Even mode sends the plain XOR of the byte; odd mode sends its inverse.
  assign parity_bit = (^data_q) ^ (mode_q == 2'b01);

  // Outputs are registered: every line/ready change happens on the same
  // edge as the state transition that causes it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      bit_cnt   <= 16'd0;
      bit_idx   <= 3'd0;
      data_q    <= 8'd0;
      mode_q    <= 2'd0;
      tx_pin    <= IDLE_LEVEL;
      tx_ready  <= 1'b1;
      tx_done   <= 1'b0;
      frame_cnt <= 16'd0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        S_IDLE: begin
          bit_cnt <= 16'd0;
          bit_idx <= 3'd0;
          if (tx_data_en) begin
            data_q   <= tx_data;
            mode_q   <= parity_mode;
            state    <= S_START;
            tx_pin   <= 1'b0;
            tx_ready <= 1'b0;
          end
        end
        S_START: begin
          if (bit_end) begin
            bit_cnt <= 16'd0;
            state   <= S_DATA;
            tx_pin  <= data_q[0];
          end else begin
            bit_cnt <= bit_cnt + 16'd1;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            bit_cnt <= 16'd0;
            if (bit_idx == 3'd7) begin
              bit_idx <= 3'd0;
              if (has_parity) begin
                state  <= S_PARITY;
                tx_pin <= parity_bit;
              end else begin
                state  <= S_STOP;
                tx_pin <= 1'b1;
              end
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx_pin  <= data_q[bit_idx + 3'd1];
            end
          end else begin
            bit_cnt <= bit_cnt + 16'd1;
          end
        end
        S_PARITY: begin
          if (bit_end) begin
            bit_cnt <= 16'd0;
            state   <= S_STOP;
            tx_pin  <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 16'd1;
          end
        end
        S_STOP: begin
          if (bit_end) begin
            bit_cnt   <= 16'd0;
            state     <= S_IDLE;
            tx_pin    <= IDLE_LEVEL;
            tx_ready  <= 1'b1;
            tx_done   <= 1'b1;
            frame_cnt <= frame_cnt + 16'd1;
          end else begin
            bit_cnt <= bit_cnt + 16'd1;
          end
        end
        default: begin
          state    <= S_IDLE;
          bit_cnt  <= 16'd0;
          bit_idx  <= 3'd0;
          tx_pin   <= IDLE_LEVEL;
          tx_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Scoreboard bench for uart_tx_serializer: stimulus pushes expected frames,
// a line monitor reassembles what appears on tx_pin and compares.
module tb_uart_tx_serializer;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [7:0]  tx_data = 8'd0;
  logic        tx_data_en = 1'b0;
  logic [1:0]  parity_mode = 2'd0;
  logic        tx_pin;
  logic        tx_ready;
  logic        tx_done;
  logic [15:0] frame_cnt;

  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .IDLE_LEVEL(1'b1)) dut (
    .clk(clk),
    .resetn(resetn),
    .tx_data(tx_data),
    .tx_data_en(tx_data_en),
    .parity_mode(parity_mode),
    .tx_pin(tx_pin),
    .tx_ready(tx_ready),
    .tx_done(tx_done),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] bits;
    int          nbits;
  } frame_t;

  frame_t      exp_q[$];
  logic [15:0] exp_cnt = 16'd0;
  int          compared = 0;
  int          mismatched = 0;
  int          cyc = 0;
  bit          mon_busy = 1'b0;
  bit          check_gap = 1'b0;
  int          mon_done_cyc = -100;

  always @(posedge clk) cyc++;

  // Reference frame straight from the line format: start, data LSB first,
  // optional parity chosen from the number of ones, stop.
  function automatic frame_t model(input logic [7:0] data, input logic [1:0] mode);
    frame_t f;
    int ones;
    f.bits = '0;
    f.bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) f.bits[i + 1] = data[i];
    f.nbits = 9;
    ones = $countones(data);
    if (mode == 2'b10) begin
      f.bits[f.nbits] = ((ones % 2) == 1);
      f.nbits++;
    end else if (mode == 2'b01) begin
      f.bits[f.nbits] = ((ones % 2) == 0);
      f.nbits++;
    end
    f.bits[f.nbits] = 1'b1;
    f.nbits++;
    return f;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    compared++;
    if (act !== expv) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Line monitor: a low level on an idle line opens a frame.
  initial begin
    frame_t e;
    int bad_bits, bad_ready, bad_done;
    bit aborted;
    forever begin
      @(negedge clk);
      if (resetn && !mon_busy && tx_pin === 1'b0) begin
        if (check_gap) begin
          checkOutput("b2b_gap", cyc - mon_done_cyc, 1);
          check_gap = 1'b0;
        end
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_frame", 1, 0);
        end else begin
          e = exp_q.pop_front();
          mon_busy = 1'b1;
          aborted = 1'b0;
          bad_bits = 0;
          bad_ready = 0;
          bad_done = 0;
          for (int s = 0; s < e.nbits * CPB; s++) begin
            if (s > 0) @(negedge clk);
            if (!resetn) begin
              aborted = 1'b1;
              break;
            end
            if (tx_pin !== e.bits[s / CPB]) bad_bits++;
            if (tx_ready !== 1'b0) bad_ready++;
            if (tx_done !== 1'b0) bad_done++;
          end
          if (!aborted) begin
            checkOutput("frame_bits", bad_bits, 0);
            checkOutput("ready_low_in_frame", bad_ready, 0);
            checkOutput("done_low_in_frame", bad_done, 0);
            @(negedge clk);
            if (resetn) begin
              exp_cnt = exp_cnt + 16'd1;
              checkOutput("done_pulse", tx_done, 1);
              checkOutput("ready_after_stop", tx_ready, 1);
              checkOutput("frame_cnt", frame_cnt, exp_cnt);
              checkOutput("idle_level", tx_pin, 1);
              mon_done_cyc = cyc;
            end
          end
          mon_busy = 1'b0;
        end
      end
    end
  end

  task automatic applyStimulus(input logic [7:0] data, input logic [1:0] mode);
    int waited = 0;
    @(negedge clk);
    while (tx_ready !== 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (tx_ready !== 1'b1) begin
      checkOutput("ready_timeout", 0, 1);
      return;
    end
    tx_data = data;
    parity_mode = mode;
    tx_data_en = 1'b1;
    exp_q.push_back(model(data, mode));
    @(negedge clk);
    tx_data_en = 1'b0;
    tx_data = 8'($urandom);
    parity_mode = 2'($urandom);
  endtask

  task automatic waitIdle();
    int waited = 0;
    while ((exp_q.size() != 0 || mon_busy || tx_ready !== 1'b1) && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 2000) checkOutput("idle_timeout", 0, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic doReset();
    #2;
    resetn = 1'b0;
    #1;
    checkOutput("rst_tx_pin", tx_pin, 1);
    checkOutput("rst_tx_ready", tx_ready, 1);
    checkOutput("rst_tx_done", tx_done, 0);
    checkOutput("rst_frame_cnt", frame_cnt, 0);
    exp_cnt = 16'd0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    checkOutput("reset_tx_pin", tx_pin, 1);
    checkOutput("reset_tx_ready", tx_ready, 1);
    checkOutput("reset_tx_done", tx_done, 0);
    checkOutput("reset_frame_cnt", frame_cnt, 0);
    resetn = 1'b1;

    applyStimulus(8'hA5, 2'b00);
    waitIdle();
    applyStimulus(8'h07, 2'b10);
    waitIdle();
    applyStimulus(8'h07, 2'b01);
    waitIdle();
    applyStimulus(8'h5A, 2'b11);
    waitIdle();

    // Second strobe lands mid-frame and must leave the latched byte alone.
    applyStimulus(8'h55, 2'b00);
    repeat (4) @(negedge clk);
    tx_data = 8'hFF;
    parity_mode = 2'b10;
    tx_data_en = 1'b1;
    @(negedge clk);
    tx_data_en = 1'b0;
    waitIdle();

    applyStimulus(8'h3C, 2'b10);
    @(negedge clk);
    check_gap = 1'b1;
    applyStimulus(8'hC3, 2'b01);
    waitIdle();

    // Abort during data bit 3, then confirm the next byte is clean.
    applyStimulus(8'h96, 2'b00);
    repeat (17) @(negedge clk);
    doReset();
    applyStimulus(8'h69, 2'b10);
    waitIdle();

    for (int i = 0; i < 10; i++) begin
      applyStimulus(8'($urandom), 2'($urandom));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    waitIdle();

    @(negedge clk);
    force dut.frame_cnt = 16'hFFFF;
    #1;
    release dut.frame_cnt;
    exp_cnt = 16'hFFFF;
    applyStimulus(8'hE1, 2'b00);
    waitIdle();
    checkOutput("wrap_frame_cnt", frame_cnt, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/uart_tx_serializer.md
UART_TX_SERIALIZER -- requirements
Module: uart_tx_serializer

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, clk cycles per serial bit (50 MHz / 115200); legal range 2..65535.
REQ-002 Parameter IDLE_LEVEL, default 1'b1, line level driven when no frame is active.
REQ-003 clk  input  1  system clock, all logic on rising edge.
REQ-004 resetn  input  1  reset, asynchronous, active-low.
REQ-005 tx_data  input  8  byte to send, LSB first; upstream connects its buffer data [7:0].
REQ-006 tx_data_en  input  1  one-cycle request strobe qualifying tx_data.
REQ-007 parity_mode  input  2  00 none, 01 odd, 10 even, 11 none; driven from the control register verify field.
REQ-008 tx_pin  output  1  serial line.
REQ-009 tx_ready  output  1  high when idle and able to accept a byte.
REQ-010 tx_done  output  1  one-cycle pulse when a frame's stop bit completes.
REQ-011 frame_cnt  output  16  count of completed frames, wraps modulo 2^16.

Function
REQ-012 States: IDLE, START, DATA, PARITY, STOP. The encoding is free; states are not visible at the ports.
REQ-013 A byte is accepted only on a rising edge where tx_data_en=1 and the state is IDLE.
- On accept, tx_data and parity_mode are latched.
- The block enters START.
REQ-014 tx_data_en while not IDLE is ignored; the latched byte and parity mode are not disturbed.
REQ-015 tx_ready = 1 in IDLE only, registered.
- It drops on the cycle after acceptance.
- It must be low at most 1 cycle after the tx_data_en edge, because upstream re-samples ready 3 cycles later.
REQ-016 tx_pin is registered.
- It goes low on the first cycle after acceptance, giving 1-cycle latency.
- Every bit, including start, each data bit, parity and stop, is held for exactly CLKS_PER_BIT cycles.
REQ-017 The bit counter counts 0..CLKS_PER_BIT-1.
- At terminal count it reloads 0 and the block advances to the next bit or state.
- The counter is held at 0 in IDLE.
REQ-018 DATA sends tx_data[0] first through tx_data[7], using a 3-bit index.
- After index 7 completes, the next state is PARITY if the latched mode is 01 or 10, else STOP.
REQ-019 Parity bit value:
- Even mode: XOR of the 8 latched bits.
- Odd mode: inverse of that XOR.
REQ-020 STOP drives 1 for one bit time.
- At its terminal count: tx_done pulses for 1 cycle, frame_cnt increments, and the state returns to IDLE.
REQ-021 tx_ready reasserts on the same edge that tx_done asserts.
- A tx_data_en in that cycle is not accepted, because the state is not yet IDLE.
- A request on the following cycle is accepted, giving back-to-back frames with no idle bit beyond the stop bit.
REQ-022 Frame length in clk cycles:
- 10*CLKS_PER_BIT without parity.
- 11*CLKS_PER_BIT with parity.
- Plus 1 cycle of IDLE between back-to-back frames.
REQ-023 frame_cnt wraps from 16'hFFFF to 16'h0000 with no flag.
REQ-024 A parity_mode change mid-frame has no effect until the next accept.

Reset
REQ-025 Reset asserted at any time, including mid-frame, forces the following immediately (asynchronous):
- state IDLE
- tx_pin = IDLE_LEVEL
- tx_ready = 1
- tx_done = 0
- frame_cnt = 0
- bit counter and data index = 0
- latched data and latched mode = 0
REQ-026 A frame aborted by reset is not resumed or counted.
- The first edge after deassertion may accept a new byte.

Verification (bench uses CLKS_PER_BIT=4)
REQ-027 Mode 00, tx_data=8'hA5, 1-cycle strobe:
- tx_pin bits, each 4 cycles: 0,1,0,1,0,0,1,0,1,1.
- tx_ready low for 40 cycles.
- One tx_done pulse; frame_cnt=1.
REQ-028 Mode 10, 8'h07:
- Parity bit = 1, frame 44 cycles.
- Mode 01, 8'h07: parity bit = 0.
REQ-029 Strobe 8'h55 with a second strobe of 8'hFF at cycle +5:
- The second strobe is ignored.
- The line shows only 8'h55; frame_cnt increments by exactly 1.
REQ-030 Back-to-back frames, with the strobe issued the cycle after tx_done:
- Second start bit begins 2 cycles after the first stop bit ends.
- frame_cnt=2.
REQ-031 Reset pulsed during DATA bit 3:
- tx_pin=1 and tx_ready=1 immediately; frame_cnt=0.
- The next byte transmits correctly.
REQ-032 Preload 65535 completed frames (or force frame_cnt=16'hFFFF), then send one frame:
- frame_cnt=0 and tx_done pulses.
